pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It drives the stall and flush controls of every pipeline register (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and the PC hold. It sources these from four conditions: load-use hazards, multi-cycle divides in EXE, data-cache miss handshakes in MEM, and exceptions committed in MEM. It sits beside the datapath and owns all pipeline-register control; no other block asserts these signals.

---
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: hazard sources from the datapath and the
// per-register stall/flush controls returned by the hazard sequencer.
interface pipe_hazard_ctrl_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic [4:0]  EXE_Dst;
  logic        EXE_IsLoad;
  logic        EXE_IsDiv;
  logic        EXE_BranchTaken;
  logic        MEM_MemReq;
  logic        MEM_ExceptValid;
  logic        DCache_Ack;

  logic        PC_Stall;
  logic        IFID_Stall;
  logic        IDEXE_Stall;
  logic        EXEMEM_Stall;
  logic        IFID_Flush;
  logic        IDEXE_Flush;
  logic        EXEMEM_Flush;
  logic        MEMWB_Flush;
  logic        PC_ExcRedirect;
  logic        DCache_Req;
  logic        Div_Start;
  logic        Div_Done;
  logic [31:0] Stall_Cnt;

  // Sequencer side: owns every pipeline-register control.
  modport master (
    input  ID_rs, ID_rt, EXE_Dst, EXE_IsLoad, EXE_IsDiv, EXE_BranchTaken,
           MEM_MemReq, MEM_ExceptValid, DCache_Ack,
    output PC_Stall, IFID_Stall, IDEXE_Stall, EXEMEM_Stall,
           IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush,
           PC_ExcRedirect, DCache_Req, Div_Start, Div_Done, Stall_Cnt
  );

  // Datapath side.
  modport slave (
    output ID_rs, ID_rt, EXE_Dst, EXE_IsLoad, EXE_IsDiv, EXE_BranchTaken,
           MEM_MemReq, MEM_ExceptValid, DCache_Ack,
    input  PC_Stall, IFID_Stall, IDEXE_Stall, EXEMEM_Stall,
           IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush,
           PC_ExcRedirect, DCache_Req, Div_Start, Div_Done, Stall_Cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: load-use,
// multi-cycle divide, D-cache miss and MEM-stage exception handling.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DIV_LATENCY);
  localparam int unsigned SCW   = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCW-1:0]   stall_cnt_q;

  logic pc_stall, ifid_stall, idexe_stall, exemem_stall;
  logic ifid_flush, idexe_flush, exemem_flush, memwb_flush;
  logic exc_redirect, dcache_req, div_start, div_done;
  logic load_use;

  assign load_use = bus.EXE_IsLoad && (bus.EXE_Dst != 5'd0) &&
                    ((bus.EXE_Dst == bus.ID_rs) || (bus.EXE_Dst == bus.ID_rt));

  // Next state and pipeline controls; everything is forced low during reset.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idexe_stall  = 1'b0;
    exemem_stall = 1'b0;
    ifid_flush   = 1'b0;
    idexe_flush  = 1'b0;
    exemem_flush = 1'b0;
    memwb_flush  = 1'b0;
    exc_redirect = 1'b0;
    dcache_req   = 1'b0;
    div_start    = 1'b0;
    div_done     = 1'b0;

    if (!rst) begin
      case (state_q)
        RUN: begin
          if (bus.MEM_ExceptValid) begin
            exc_redirect = 1'b1;
            ifid_flush   = 1'b1;
            idexe_flush  = 1'b1;
            exemem_flush = 1'b1;
            memwb_flush  = 1'b1;
          end else if (bus.MEM_MemReq) begin
            dcache_req = 1'b1;
            if (!bus.DCache_Ack) begin
              pc_stall     = 1'b1;
              ifid_stall   = 1'b1;
              idexe_stall  = 1'b1;
              exemem_stall = 1'b1;
              memwb_flush  = 1'b1;
              state_d      = MEM_BUSY;
            end
          end else if (bus.EXE_IsDiv) begin
            div_start    = 1'b1;
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idexe_stall  = 1'b1;
            exemem_flush = 1'b1;
            cnt_d        = CNT_W'(DIV_LATENCY - 1);
            state_d      = DIV_BUSY;
          end else begin
            // A taken branch in EXE is never a load, so these two never collide.
            ifid_flush = bus.EXE_BranchTaken;
            if (load_use) begin
              pc_stall    = 1'b1;
              ifid_stall  = 1'b1;
              idexe_flush = 1'b1;
            end
          end
        end

        MEM_BUSY: begin
          dcache_req = 1'b1;
          if (bus.DCache_Ack) begin
            state_d = RUN;
          end else begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idexe_stall  = 1'b1;
            exemem_stall = 1'b1;
            memwb_flush  = 1'b1;
          end
        end

        DIV_BUSY: begin
          if (cnt_q != '0) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idexe_stall  = 1'b1;
            exemem_flush = 1'b1;
            cnt_d        = cnt_q - CNT_W'(1);
          end else begin
            div_done = 1'b1;
            state_d  = RUN;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall) stall_cnt_q <= stall_cnt_q + SCW'(1);
    end
  end

  assign bus.PC_Stall       = pc_stall;
  assign bus.IFID_Stall     = ifid_stall;
  assign bus.IDEXE_Stall    = idexe_stall;
  assign bus.EXEMEM_Stall   = exemem_stall;
  assign bus.IFID_Flush     = ifid_flush;
  assign bus.IDEXE_Flush    = idexe_flush;
  assign bus.EXEMEM_Flush   = exemem_flush;
  assign bus.MEMWB_Flush    = memwb_flush;
  assign bus.PC_ExcRedirect = exc_redirect;
  assign bus.DCache_Req     = dcache_req;
  assign bus.Div_Start      = div_start;
  assign bus.Div_Done       = div_done;
  assign bus.Stall_Cnt      = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DIV_LAT = 4;

  logic clk = 1'b0;
  logic rst;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.DIV_LATENCY(DIV_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: "waiting for cache", "dividing" with cycles of the divide spent so far.
  bit          m_miss    = 1'b0;
  bit          m_div     = 1'b0;
  int          m_div_age = 0;
  logic [31:0] m_scnt    = 32'd0;

  logic [11:0] obs_ctl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // {PCs, IFIDs, IDEXEs, EXEMEMs, IFIDf, IDEXEf, EXEMEMf, MEMWBf, Redir, Req, DivStart, DivDone}
  function automatic logic [11:0] dut_ctl();
    return {bus.PC_Stall, bus.IFID_Stall, bus.IDEXE_Stall, bus.EXEMEM_Stall,
            bus.IFID_Flush, bus.IDEXE_Flush, bus.EXEMEM_Flush, bus.MEMWB_Flush,
            bus.PC_ExcRedirect, bus.DCache_Req, bus.Div_Start, bus.Div_Done};
  endfunction

  function automatic logic [11:0] model_ctl();
    logic [11:0] STALL4_MWF = 12'hF10;  // four stalls + MEM/WB bubble
    logic [11:0] DIV_HOLD   = 12'hE20;  // front three stalls + EXE/MEM bubble
    logic [11:0] e = 12'h000;
    if (rst) return 12'h000;
    if (m_miss) begin
      e[2] = 1'b1;
      if (!bus.DCache_Ack) e |= STALL4_MWF;
    end else if (m_div) begin
      if (m_div_age < int'(DIV_LAT)) e = DIV_HOLD;
      else e[0] = 1'b1;
    end else if (bus.MEM_ExceptValid) begin
      e = 12'h0F8;
    end else if (bus.MEM_MemReq) begin
      e[2] = 1'b1;
      if (!bus.DCache_Ack) e |= STALL4_MWF;
    end else if (bus.EXE_IsDiv) begin
      e = DIV_HOLD | 12'h002;
    end else begin
      e[7] = bus.EXE_BranchTaken;
      if (bus.EXE_IsLoad && bus.EXE_Dst != 5'd0 &&
          (bus.EXE_Dst == bus.ID_rs || bus.EXE_Dst == bus.ID_rt))
        e |= 12'hC40;
    end
    return e;
  endfunction

  task automatic model_update(input logic pc_stall);
    if (rst) begin
      m_miss = 1'b0; m_div = 1'b0; m_div_age = 0; m_scnt = 32'd0;
    end else begin
      if (pc_stall) m_scnt = m_scnt + 32'd1;
      if (m_miss) m_miss = !bus.DCache_Ack;
      else if (m_div) begin
        if (m_div_age < int'(DIV_LAT)) m_div_age++;
        else m_div = 1'b0;
      end else if (!bus.MEM_ExceptValid && bus.MEM_MemReq) m_miss = !bus.DCache_Ack;
      else if (!bus.MEM_ExceptValid && bus.EXE_IsDiv) begin
        m_div = 1'b1; m_div_age = 1;
      end
    end
  endtask

  // Inputs are set by the caller just after a rising edge; sampled 2 time units later.
  task automatic run_cycle();
    logic [11:0] e;
    #2;
    e = model_ctl();
    obs_ctl = dut_ctl();
    check_eq("ctl", 32'(obs_ctl), 32'(e));
    check_eq("stall_cnt", bus.Stall_Cnt, rst ? 32'd0 : m_scnt);
    @(posedge clk);
    model_update(e[11]);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ID_rs = 5'd0; bus.ID_rt = 5'd0; bus.EXE_Dst = 5'd0;
    bus.EXE_IsLoad = 1'b0; bus.EXE_IsDiv = 1'b0; bus.EXE_BranchTaken = 1'b0;
    bus.MEM_MemReq = 1'b0; bus.MEM_ExceptValid = 1'b0; bus.DCache_Ack = 1'b0;
  endtask

  initial begin
    logic [31:0] s0;
    int n_req, n_stall, n_mwf, n_done;

    rst = 1'b1;
    clear_inputs();
    bus.MEM_ExceptValid = 1'b1;  // outputs must stay low under reset regardless
    run_cycle();
    check_eq("rst_ctl", 32'(obs_ctl), 32'd0);
    clear_inputs();
    run_cycle();
    rst = 1'b0;

    // Load-use, then the same with r0 as destination
    bus.EXE_IsLoad = 1'b1; bus.EXE_Dst = 5'd5; bus.ID_rs = 5'd5; bus.ID_rt = 5'd7;
    run_cycle();
    check_eq("load_use", 32'(obs_ctl), 32'h0C40);
    bus.EXE_Dst = 5'd0; bus.ID_rs = 5'd0;
    run_cycle();
    check_eq("load_use_r0", 32'(obs_ctl), 32'h0000);
    clear_inputs();

    // Divide: start, DIV_LAT stall cycles, done pulse
    s0 = bus.Stall_Cnt;
    bus.EXE_IsDiv = 1'b1;
    run_cycle();
    check_eq("div_start", 32'(obs_ctl[1]), 32'd1);
    for (int i = 1; i < int'(DIV_LAT); i++) run_cycle();
    run_cycle();
    check_eq("div_done", 32'(obs_ctl[0]), 32'd1);
    check_eq("div_stall_cnt", bus.Stall_Cnt - s0, 32'(DIV_LAT));
    clear_inputs();

    // Cache miss, ack three cycles after the request
    n_req = 0; n_stall = 0; n_mwf = 0;
    bus.MEM_MemReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.DCache_Ack = (i == 3);
      run_cycle();
      n_req += int'(obs_ctl[2]); n_stall += int'(obs_ctl[11]); n_mwf += int'(obs_ctl[4]);
    end
    check_eq("miss_req_cycles", 32'(n_req), 32'd4);
    check_eq("miss_stall_cycles", 32'(n_stall), 32'd3);
    check_eq("miss_mwf_cycles", 32'(n_mwf), 32'd3);
    clear_inputs();
    run_cycle();
    check_eq("miss_back_run", 32'(obs_ctl), 32'd0);

    // Exception beats miss, divide and branch
    bus.MEM_ExceptValid = 1'b1; bus.MEM_MemReq = 1'b1;
    bus.EXE_IsDiv = 1'b1; bus.EXE_BranchTaken = 1'b1;
    run_cycle();
    check_eq("exc_prio", 32'(obs_ctl), 32'h00F8);
    clear_inputs();

    // Divide waiting behind a miss: Div_Start only after Ack
    bus.MEM_MemReq = 1'b1; bus.EXE_IsDiv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.DCache_Ack = (i == 2);
      run_cycle();
      check_eq("div_deferred", 32'(obs_ctl[1]), 32'd0);
    end
    bus.MEM_MemReq = 1'b0; bus.DCache_Ack = 1'b0;
    run_cycle();
    check_eq("div_after_ack", 32'(obs_ctl[1]), 32'd1);
    for (int i = 0; i < int'(DIV_LAT); i++) run_cycle();
    check_eq("div_after_ack_done", 32'(obs_ctl[0]), 32'd1);
    clear_inputs();

    // Reset in the middle of a divide
    bus.EXE_IsDiv = 1'b1;
    run_cycle();
    run_cycle();
    rst = 1'b1;
    run_cycle();
    check_eq("rst_mid_div_ctl", 32'(obs_ctl), 32'd0);
    check_eq("rst_mid_div_cnt", bus.Stall_Cnt, 32'd0);
    rst = 1'b0;
    clear_inputs();
    n_done = 0;
    for (int i = 0; i < int'(DIV_LAT) + 2; i++) begin
      run_cycle();
      n_done += int'(obs_ctl[0]);
    end
    check_eq("rst_no_div_done", 32'(n_done), 32'd0);
    check_eq("rst_cnt_zero", bus.Stall_Cnt, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      bus.ID_rs = 5'($urandom_range(3));
      bus.ID_rt = 5'($urandom_range(3));
      bus.EXE_Dst = 5'($urandom_range(3));
      bus.EXE_BranchTaken = ($urandom_range(5) == 0);
      bus.EXE_IsLoad = !bus.EXE_BranchTaken && ($urandom_range(2) == 0);
      bus.EXE_IsDiv = ($urandom_range(7) == 0);
      bus.MEM_MemReq = ($urandom_range(3) == 0);
      bus.MEM_ExceptValid = ($urandom_range(9) == 0);
      bus.DCache_Ack = ($urandom_range(1) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
